// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage register with valid/ready handshake, stall, flush and bubble gating.
// Define EX_MEM_SKID_EN to build it as a 2-entry skid buffer with a registered in_ready.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              live_q;
  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer, out_xfer;

  assign out_xfer = main_v_q & out_ready;
  assign in_xfer  = in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              rdy_q;

  // Readiness depends only on registered skid occupancy, never on out_ready.
  assign in_ready = rdy_q & ~stall & ~flush;

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end else begin
        main_v_d    = in_xfer;
        main_ctrl_d = in_xfer ? in_ctrl : main_ctrl_q;
        main_data_d = in_xfer ? in_data : main_data_q;
      end
    end else if (in_xfer) begin
      if (!main_v_q) begin
        main_v_d    = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        skid_v_d    = 1'b1;
        skid_ctrl_d = in_ctrl;
        skid_data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= ~skid_v_d;
    end
  end
`else
  assign in_ready = live_q & ~stall & ~flush & (~main_v_q | out_ready);

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    if (flush) begin
      main_v_d = 1'b0;
    end else if (in_xfer) begin
      main_v_d    = 1'b1;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (out_xfer) begin
      main_v_d = 1'b0;
    end
  end
`endif

  assign cnt_d = (in_valid & ~in_ready) ? sat_inc(cnt_q) : cnt_q;

  // Stage register: payload and handshake state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q      <= 1'b0;
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      live_q      <= 1'b1;
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = main_v_q;
  // Bubbles carry all-zero control so they can never write the register file.
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_v_q}};
  assign out_data  = main_data_q;
  assign stall_cnt = cnt_q;

`ifndef EX_MEM_SKID_EN
  logic unused_live;
  assign unused_live = live_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed self-checking bench for ex_mem_pipe_stage (default single-register build).
module tb_ex_mem_pipe_stage;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;
  int checks = 0;
  int failures = 0;

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rdy_before_edge", {63'd0, in_ready}, 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ctrl", {48'd0, out_ctrl}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("rst_rdy", {63'd0, in_ready}, 64'd0);
    tick();
    release_reset();
    chk("rdy_after_edge", {63'd0, in_ready}, 64'd1);

    // Streaming: 1,2,3,4 back to back, no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CTRL_W'(16 + i), DATA_W'(i));
      #1;
      chk("stream_rdy", {63'd0, in_ready}, 64'd1);
      tick();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_data", {32'd0, out_data}, 64'(i));
      chk("stream_ctrl", {48'd0, out_ctrl}, 64'(16 + i));
    end
    drive(1'b0, 16'h00AA, '0);
    tick();
    chk("bubble_valid", {63'd0, out_valid}, 64'd0);
    chk("bubble_ctrl", {48'd0, out_ctrl}, 64'd0);
    chk("stream_cnt", {60'd0, stall_cnt}, 64'd0);

    // Backpressure: A5 held while B6 is offered
    drive(1'b1, 16'h005A, 32'hA5);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h006B, 32'hB6);
    #1;
    chk("bp_rdy", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", {32'd0, out_data}, 64'hA5);
      chk("bp_ctrl", {48'd0, out_ctrl}, 64'h5A);
    end
    chk("bp_cnt", {60'd0, stall_cnt}, 64'd3);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_next_data", {32'd0, out_data}, 64'hB6);
    chk("bp_cnt_hold", {60'd0, stall_cnt}, 64'd3);

    // Asynchronous reset mid-stream, between clock edges
    drive(1'b0, '0, '0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ctrl", {48'd0, out_ctrl}, 64'd0);
    chk("mid_rst_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("mid_rst_rdy", {63'd0, in_ready}, 64'd0);
    release_reset();

    // Flush drops the concurrent input and clears the stage
    drive(1'b1, 16'hFFFF, 32'h77);
    tick();
    chk("fl_pre_ctrl", {48'd0, out_ctrl}, 64'hFFFF);
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'h1234, 32'h88);
    #1;
    chk("fl_rdy", {63'd0, in_ready}, 64'd0);
    tick();
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ctrl", {48'd0, out_ctrl}, 64'd0);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    chk("fl_dropped", {63'd0, out_valid}, 64'd0);
    chk("fl_cnt", {60'd0, stall_cnt}, 64'd1);

    // Stall and flush together: flush wins
    out_ready = 1'b1;
    drive(1'b1, 16'h0033, 32'h99);
    tick();
    out_ready = 1'b0;
    stall = 1'b1; flush = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    chk("sf_valid", {63'd0, out_valid}, 64'd0);
    chk("sf_ctrl", {48'd0, out_ctrl}, 64'd0);

    // Stall alone freezes contents for two cycles
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 16'h000F, 32'h44);
    tick();
    stall = 1'b1;
    drive(1'b1, 16'h00F0, 32'h55);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("st_rdy", {63'd0, in_ready}, 64'd0);
      tick();
      chk("st_valid", {63'd0, out_valid}, 64'd1);
      chk("st_data", {32'd0, out_data}, 64'h44);
      chk("st_ctrl", {48'd0, out_ctrl}, 64'h0F);
    end
    chk("st_cnt", {60'd0, stall_cnt}, 64'd3);

    // Output transfer during stall still drains the entry
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    #1;
    chk("st_drain_rdy", {63'd0, in_ready}, 64'd0);
    tick();
    chk("st_drain_valid", {63'd0, out_valid}, 64'd0);
    stall = 1'b0;

    // Saturation of the 4-bit stall counter
    rst = 1'b0;
    #1;
    release_reset();
    stall = 1'b1;
    drive(1'b1, 16'h0001, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) chk("sat_cnt10", {60'd0, stall_cnt}, 64'd10);
      if (i == 15) chk("sat_cnt15", {60'd0, stall_cnt}, 64'd15);
    end
    chk("sat_cnt20", {60'd0, stall_cnt}, 64'd15);
    chk("sat_valid", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
